sine_gen_mc: RTL and testbench
==============================

Name: sine_gen_mc

Overview:
Multi-channel recursive sine oscillator; parametrised successor of the single-channel sine generator.
- NCH independent phasor rotators share one signed WL x WL multiplier, time-multiplexed round-robin.
- Per-channel frequency (cosW/sinW) and amplitude are loaded through a write port. The top level drives this port from the APB cfg register file.
- Sits between freq2trig/APB config and the output pins. Emits a tagged sample stream plus a flat bus of the latest sample per channel.

Parameters:
WL, 16, sample and coefficient word length; coefficients are signed Q1.(WL-1)
NCH, 4, number of channels, >=1
CH_WL, $clog2(NCH) (min 1), channel index width

Ports:
clk  in  1  clock
reset_b  in  1  async active-low reset
en  in  1  sequencer run enable
load  in  1  one-cycle write strobe for channel load_ch
load_ch  in  CH_WL  channel being written
load_cos  in  WL  cosW for the channel
load_sin  in  WL  sinW for the channel
load_amp  in  WL  initial amplitude; x <= amp, y <= 0
sine_valid  out  1  one-cycle strobe, new sample on sine/sine_ch
sine_ch  out  CH_WL  channel of the current sample
sine  out  WL  new y of that channel
sine_all  out  NCH*WL  latest y per channel; channel k at [k*WL +: WL]

Behaviour:
- Reset (async, reset_b=0):
  - All x, y, cos, sin registers = 0.
  - Phase = P0, ch = 0, acc = 0.
  - sine_valid = 0, sine_ch = 0, sine = 0, sine_all = 0.
- Per-channel state: x, y, cos, sin (each WL bits); shared xt (WL bits) holds x_new.
- Sequencer FSM P0 -> P1 -> P2 -> P3 -> P0; one phase per cycle while en=1.
  - P0: acc = x*cos
  - P1: xt = sat(rnd(acc - y*sin))
  - P2: acc = y*cos
  - P3: y_new = sat(rnd(acc + x*sin)); x <= xt; y <= y_new. x, y here are the pre-update values.
- P3 register update: sine <= y_new, sine_ch <= ch, sine_all[ch] <= y_new, sine_valid = 1 on the following cycle.
- After P3, ch wraps to 0 when ch == NCH-1, else increments.
- Timing: one sample every 4 cycles; each channel updates every 4*NCH cycles.
- Arithmetic:
  - Products are 2*WL bits signed; acc is 2*WL+1 bits.
  - rnd(a) = (a + 2^(WL-2)) >>> (WL-1), arithmetic shift.
  - sat clamps to [-2^(WL-1), 2^(WL-1)-1].
- en=0: phase, ch, acc and xt freeze; sine_valid = 0; sine/sine_all hold; loads still accepted. Resuming continues from the frozen phase.
- load=1: next edge writes cos[load_ch], sin[load_ch], x[load_ch]=amp, y[load_ch]=0.
- Load to the channel currently in P1..P3: that channel's P3 write-back of x/y/sine_all is suppressed, and sine_valid stays 0 for that slot. The load values win and the sequencer advances normally.
- Load in the same cycle as P3 of the same channel: the load wins, same as above.
- load_ch >= NCH: ignored.
- No back-pressure: consumers must accept sine_valid every cycle it is asserted.

Decomposition:
- Package sine_gen_pkg:
  - phase enum (P0..P3)
  - localparam RND = 1 << (WL-2)
  - function sat_wl (2*WL+1 -> WL)
- One sub-module, sine_mac: registered multiply-accumulate with op select (load/sub/add).
  - Holds acc; contains the only multiplier.
  - Combinational rnd/sat output.
- Channel register file and FSM live in sine_gen_mc.

Test Plan:
- Reset mid-run: assert reset_b=0 while en=1 during P2 -> all outputs 0 immediately; after release, first sine_valid exactly 4 cycles after en, with sine_ch=0.
- Quarter-rate tone: NCH=4, WL=16; ch0 loaded with cos=0x0000, sin=0x7FFF, amp=0x4000 -> successive ch0 samples 0x4000, 0x0000, 0xC000, 0x0000, 0x4000, spaced 16 cycles apart; other channels output 0x0000.
- Saturation: ch1 loaded with cos=0x7FFF, sin=0x7FFF, amp=0x7FFF -> first sample 0x7FFE, second 0x7FFF (clamped, no wrap to negative).
- Round-robin: load all 4 channels with distinct tones -> sine_ch sequence 0,1,2,3,0...; sine_valid every 4th cycle; sine_all[k] equals the last sine seen with sine_ch=k.
- Load collision: load ch2 (amp=0x1000) while ch2 is in P2 -> no sine_valid for that slot; sine_all[2] unchanged; next ch2 sample computed from x=0x1000, y=0.
- Enable gating: drop en for 7 cycles mid-P1 -> no sine_valid during the gap, and outputs hold; the sample sequence after resume is identical to an ungated run shifted by 7 cycles.

Source files
------------

// File: rtl/sine_gen_pkg.sv
// Purpose : shared types and arithmetic helpers for the multi-channel sine oscillator.
// Latency : n/a (types, constants and a combinational function only).
// Backpressure: n/a.
package sine_gen_pkg;

  // Default sample/coefficient word length.
  localparam int WL_DEF = 16;
  // Rounding constant at the default word length (half an LSB after the Q1.(WL-1) rescale).
  localparam int RND = 1 << (WL_DEF - 2);

  // Sequencer phases: one multiply per phase, four phases per sample.
  typedef enum logic [1:0] {P0, P1, P2, P3} phase_e;

  // Multiplier-accumulator operation select.
  typedef enum logic [1:0] {MAC_LOAD, MAC_SUB, MAC_ADD} mac_op_e;

  // Clamp a sign-extended value to the signed range of a wl-bit word.
  function automatic logic signed [63:0] sat_wl(input logic signed [63:0] a, input int wl);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (wl - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (wl - 1));
    if (a > hi) return hi;
    if (a < lo) return lo;
    return a;
  endfunction

endpackage

// File: rtl/sine_mac.sv
// Purpose : shared signed WLxWL multiplier with a registered accumulator and a
//           combinational round/saturate result (acc -/+ a*b).
// Latency : MAC_LOAD registers a*b on the next edge; o_res is combinational.
// Backpressure: none; i_en freezes the accumulator.
// Ports   : clk, reset_b (async active-low); i_en, i_op, i_a, i_b in; o_res out.
module sine_mac
  import sine_gen_pkg::*;
#(
  parameter int WL = WL_DEF
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 i_en,
  input  mac_op_e              i_op,
  input  logic signed [WL-1:0] i_a,
  input  logic signed [WL-1:0] i_b,
  output logic signed [WL-1:0] o_res
);

  localparam int AW = 2 * WL + 1;
  localparam logic signed [AW-1:0] C_RND = AW'(1) <<< (WL - 2);

  logic signed [AW-1:0]   r_acc;
  logic signed [2*WL-1:0] w_prod;
  logic signed [AW-1:0]   w_prod_x;
  logic signed [AW-1:0]   w_sum;
  logic signed [AW-1:0]   w_rnd;

  assign w_prod   = (2*WL)'(i_a) * (2*WL)'(i_b);
  assign w_prod_x = {w_prod[2*WL-1], w_prod};
  assign w_sum    = (i_op == MAC_SUB) ? (r_acc - w_prod_x) : (r_acc + w_prod_x);
  // Round half up, then drop the Q1.(WL-1) fractional scale.
  assign w_rnd    = (w_sum + C_RND) >>> (WL - 1);
  assign o_res    = WL'(sat_wl(64'(w_rnd), WL));

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_acc <= '0;
    end else if (i_en && (i_op == MAC_LOAD)) begin
      r_acc <= w_prod_x;
    end
  end

endmodule

// File: rtl/sine_gen_mc.sv
// Purpose : NCH recursive phasor-rotation sine oscillators sharing one multiplier,
//           served round-robin; per-channel cos/sin/amplitude load port.
// Latency : one sample every 4 cycles (each channel every 4*NCH); sine_valid one
//           cycle after the P3 edge. Backpressure: none, consumers take every strobe.
// Ports   : clk, reset_b; en, load, load_ch, load_cos, load_sin, load_amp in;
//           sine_valid, sine_ch, sine, sine_all (latest y per channel) out.
module sine_gen_mc
  import sine_gen_pkg::*;
#(
  parameter int WL    = WL_DEF,
  parameter int NCH   = 4,
  parameter int CH_WL = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              en,
  input  logic              load,
  input  logic [CH_WL-1:0]  load_ch,
  input  logic [WL-1:0]     load_cos,
  input  logic [WL-1:0]     load_sin,
  input  logic [WL-1:0]     load_amp,
  output logic              sine_valid,
  output logic [CH_WL-1:0]  sine_ch,
  output logic [WL-1:0]     sine,
  output logic [NCH*WL-1:0] sine_all
);

  logic signed [WL-1:0] r_x   [NCH];
  logic signed [WL-1:0] r_y   [NCH];
  logic signed [WL-1:0] r_cos [NCH];
  logic signed [WL-1:0] r_sin [NCH];
  logic signed [WL-1:0] r_xt;

  phase_e               r_phase;
  phase_e               w_phase_nxt;
  logic [CH_WL-1:0]     r_ch;
  logic [CH_WL-1:0]     w_ch_nxt;
  logic                 r_kill;

  logic                 r_sine_valid;
  logic [CH_WL-1:0]     r_sine_ch;
  logic [WL-1:0]        r_sine;
  logic [NCH*WL-1:0]    r_sine_all;

  mac_op_e              w_op;
  logic signed [WL-1:0] w_a;
  logic signed [WL-1:0] w_b;
  logic signed [WL-1:0] w_mac;
  logic                 w_hit;
  logic                 w_adv_p3;
  logic                 w_wb;

  sine_mac #(.WL(WL)) u_mac (
    .clk     (clk),
    .reset_b (reset_b),
    .i_en    (en),
    .i_op    (w_op),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_res   (w_mac)
  );

  // r_ch is always < NCH, so an out-of-range load_ch never hits.
  assign w_hit    = load && (load_ch == r_ch);
  assign w_adv_p3 = en && (r_phase == P3);
  // A load into the channel mid-computation invalidates this slot's result.
  assign w_wb     = w_adv_p3 && !r_kill && !w_hit;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_phase <= P0;
      r_ch    <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      r_ch    <= w_ch_nxt;
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_ch_nxt    = r_ch;
    w_op        = MAC_LOAD;
    w_a         = r_x[r_ch];
    w_b         = r_cos[r_ch];
    case (r_phase)
      P0: begin
        if (en) w_phase_nxt = P1;
      end
      P1: begin
        w_op = MAC_SUB;
        w_a  = r_y[r_ch];
        w_b  = r_sin[r_ch];
        if (en) w_phase_nxt = P2;
      end
      P2: begin
        w_a = r_y[r_ch];
        if (en) w_phase_nxt = P3;
      end
      default: begin
        w_op = MAC_ADD;
        w_b  = r_sin[r_ch];
        if (en) begin
          w_phase_nxt = P0;
          w_ch_nxt    = (r_ch == CH_WL'(NCH - 1)) ? '0 : r_ch + CH_WL'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int k = 0; k < NCH; k++) begin
        r_x[k]   <= '0;
        r_y[k]   <= '0;
        r_cos[k] <= '0;
        r_sin[k] <= '0;
      end
      r_xt         <= '0;
      r_kill       <= 1'b0;
      r_sine_valid <= 1'b0;
      r_sine_ch    <= '0;
      r_sine       <= '0;
      r_sine_all   <= '0;
    end else begin
      if (en && (r_phase == P1)) r_xt <= w_mac;
      r_sine_valid <= w_wb;
      if (w_wb) begin
        r_sine    <= w_mac;
        r_sine_ch <= r_ch;
      end
      // Remember a load that lands in P1/P2 (or P3 while stalled) until the slot ends.
      if (w_adv_p3) r_kill <= 1'b0;
      else if (w_hit && (r_phase != P0)) r_kill <= 1'b1;
      for (int k = 0; k < NCH; k++) begin
        if (w_wb && (r_ch == CH_WL'(k))) begin
          r_x[k]                  <= r_xt;
          r_y[k]                  <= w_mac;
          r_sine_all[k*WL +: WL]  <= w_mac;
        end
        // Load after write-back so it wins on any overlap.
        if (load && (load_ch == CH_WL'(k))) begin
          r_cos[k] <= load_cos;
          r_sin[k] <= load_sin;
          r_x[k]   <= load_amp;
          r_y[k]   <= '0;
        end
      end
    end
  end

  assign sine_valid = r_sine_valid;
  assign sine_ch    = r_sine_ch;
  assign sine       = r_sine;
  assign sine_all   = r_sine_all;

endmodule

// File: tb/tb_sine_gen_mc.sv
module tb_sine_gen_mc;

  typedef struct {
    int         cyc;
    logic [1:0] ch;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        en;
  logic        load;
  logic [1:0]  load_ch;
  logic [15:0] load_cos;
  logic [15:0] load_sin;
  logic [15:0] load_amp;
  logic        sine_valid;
  logic [1:0]  sine_ch;
  logic [15:0] sine;
  logic [63:0] sine_all;

  int errors = 0;
  int checks = 0;

  exp_t        exp_q[$];
  longint      m_x [4];
  longint      m_y [4];
  longint      m_c [4];
  longint      m_s [4];
  logic [15:0] m_seen [4];

  sine_gen_mc #(.WL(16), .NCH(4)) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .en         (en),
    .load       (load),
    .load_ch    (load_ch),
    .load_cos   (load_cos),
    .load_sin   (load_sin),
    .load_amp   (load_amp),
    .sine_valid (sine_valid),
    .sine_ch    (sine_ch),
    .sine       (sine),
    .sine_all   (sine_all)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: round half up, drop 15 fraction bits, clamp to 16-bit signed.
  function automatic longint rs(input longint a);
    longint r;
    r = (a + 64'sd16384) >>> 15;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  function automatic logic [63:0] seen_all();
    return {m_seen[3], m_seen[2], m_seen[1], m_seen[0]};
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < 4; k++) begin
      m_x[k] = 0; m_y[k] = 0; m_c[k] = 0; m_s[k] = 0; m_seen[k] = '0;
    end
  endfunction

  function automatic void m_load(input int ch, input logic [15:0] c, input logic [15:0] s,
                                 input logic [15:0] a);
    m_c[ch] = $signed(c);
    m_s[ch] = $signed(s);
    m_x[ch] = $signed(a);
    m_y[ch] = 0;
  endfunction

  // Advance the model for slot s and queue the sample expected at cycle cyc.
  function automatic logic [15:0] plan_slot(input int s, input int cyc);
    exp_t   e;
    int     ch;
    longint xt;
    longint yn;
    ch = s % 4;
    xt = rs(m_x[ch] * m_c[ch] - m_y[ch] * m_s[ch]);
    yn = rs(m_y[ch] * m_c[ch] + m_x[ch] * m_s[ch]);
    m_x[ch] = xt;
    m_y[ch] = yn;
    e.cyc = cyc;
    e.ch  = 2'(ch);
    e.val = yn[15:0];
    exp_q.push_back(e);
    return yn[15:0];
  endfunction

  task automatic do_reset();
    en = 1'b0; load = 1'b0; load_ch = '0;
    load_cos = '0; load_sin = '0; load_amp = '0;
    reset_b = 1'b0;
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    m_reset();
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic drive_load(input int ch, input logic [15:0] c, input logic [15:0] s,
                            input logic [15:0] a);
    load = 1'b1; load_ch = 2'(ch); load_cos = c; load_sin = s; load_amp = a;
    m_load(ch, c, s, a);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic load_tones();
    drive_load(0, 16'h7641, 16'h30FB, 16'h2000);
    drive_load(1, 16'h5A82, 16'h5A82, 16'h3000);
    drive_load(2, 16'h30FB, 16'h7641, 16'h4000);
    drive_load(3, 16'h0000, 16'h7FFF, 16'h5000);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (sine_valid !== 1'b0) begin errors++; $display("FAIL reset sine_valid: got %b want 0", sine_valid); end
    checks++;
    if (sine_ch !== 2'd0) begin errors++; $display("FAIL reset sine_ch: got %0d want 0", sine_ch); end
    checks++;
    if (sine !== 16'h0) begin errors++; $display("FAIL reset sine: got %h want 0000", sine); end
    checks++;
    if (sine_all !== 64'h0) begin errors++; $display("FAIL reset sine_all: got %h want 0", sine_all); end
  endtask

  task automatic test_quarter();
    int   c;
    exp_t e;
    logic [15:0] first0;
    do_reset();
    drive_load(0, 16'h0000, 16'h7FFF, 16'h4000);
    for (int s = 0; s < 20; s++) void'(plan_slot(s, 4 * s + 4));
    first0 = 16'hxxxx;
    en = 1'b1; c = 0;
    while (exp_q.size() > 0 && c < 200) begin
      @(negedge clk); c++;
      if (sine_valid) begin
        e = exp_q.pop_front();
        m_seen[e.ch] = e.val;
        if (c == 4) first0 = sine;
        checks++;
        if (c !== e.cyc || sine_ch !== e.ch || sine !== e.val || sine_all !== seen_all()) begin
          errors++;
          $display("FAIL quarter sample: cyc=%0d ch=%0d sine=%h all=%h want cyc=%0d ch=%0d sine=%h all=%h",
                   c, sine_ch, sine, sine_all, e.cyc, e.ch, e.val, seen_all());
        end
      end
    end
    en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL quarter timeout: %0d samples missing, want 0", exp_q.size()); end
    checks++;
    if (first0 !== 16'h4000) begin errors++; $display("FAIL quarter first ch0: got %h want 4000", first0); end
  endtask

  task automatic test_reset_mid();
    int   c;
    exp_t e;
    do_reset();
    drive_load(0, 16'h0000, 16'h7FFF, 16'h4000);
    void'(plan_slot(0, 4));
    en = 1'b1; c = 0;
    repeat (6) begin
      @(negedge clk); c++;
      if (sine_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (c !== e.cyc || sine !== e.val) begin
          errors++;
          $display("FAIL resetmid pre sample: cyc=%0d sine=%h want cyc=%0d sine=%h", c, sine, e.cyc, e.val);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL resetmid pre: %0d samples missing, want 0", exp_q.size()); end
    // Now in P2 of slot 1 with en high: assert reset between edges.
    #2 reset_b = 1'b0;
    #1;
    checks++;
    if ({sine_valid, sine_ch, sine, sine_all} !== 83'h0) begin
      errors++;
      $display("FAIL resetmid async clear: valid=%b ch=%0d sine=%h all=%h want all zero", sine_valid, sine_ch, sine, sine_all);
    end
    en = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    m_reset();
    exp_q.delete();
    @(negedge clk);
    void'(plan_slot(0, 4));
    void'(plan_slot(1, 8));
    en = 1'b1; c = 0;
    while (exp_q.size() > 0 && c < 40) begin
      @(negedge clk); c++;
      if (sine_valid) begin
        e = exp_q.pop_front();
        checks++;
        if (c !== e.cyc || sine_ch !== e.ch || sine !== e.val) begin
          errors++;
          $display("FAIL resetmid restart: cyc=%0d ch=%0d sine=%h want cyc=%0d ch=%0d sine=%h", c, sine_ch, sine, e.cyc, e.ch, e.val);
        end
      end
    end
    en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL resetmid timeout: %0d samples missing, want 0", exp_q.size()); end
  endtask

  task automatic test_saturation();
    int          c;
    exp_t        e;
    logic [15:0] got1 [$];
    do_reset();
    drive_load(1, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    for (int s = 0; s < 8; s++) void'(plan_slot(s, 4 * s + 4));
    en = 1'b1; c = 0;
    while (exp_q.size() > 0 && c < 100) begin
      @(negedge clk); c++;
      if (sine_valid) begin
        e = exp_q.pop_front();
        m_seen[e.ch] = e.val;
        if (sine_ch == 2'd1) got1.push_back(sine);
        checks++;
        if (c !== e.cyc || sine_ch !== e.ch || sine !== e.val || sine_all !== seen_all()) begin
          errors++;
          $display("FAIL sat sample: cyc=%0d ch=%0d sine=%h all=%h want cyc=%0d ch=%0d sine=%h all=%h",
                   c, sine_ch, sine, sine_all, e.cyc, e.ch, e.val, seen_all());
        end
      end
    end
    en = 1'b0;
    checks++;
    if (exp_q.size() != 0 || got1.size() != 2) begin
      errors++;
      $display("FAIL sat count: missing=%0d ch1 samples=%0d want 0 and 2", exp_q.size(), got1.size());
    end else begin
      checks++;
      if (got1[0] !== 16'h7FFE) begin errors++; $display("FAIL sat first: got %h want 7ffe", got1[0]); end
      checks++;
      if (got1[1] !== 16'h7FFF) begin errors++; $display("FAIL sat second clamp: got %h want 7fff", got1[1]); end
    end
  endtask

  task automatic test_round_robin();
    int   c;
    exp_t e;
    do_reset();
    load_tones();
    for (int s = 0; s < 24; s++) void'(plan_slot(s, 4 * s + 4));
    en = 1'b1; c = 0;
    while (exp_q.size() > 0 && c < 200) begin
      @(negedge clk); c++;
      if (sine_valid) begin
        e = exp_q.pop_front();
        m_seen[e.ch] = e.val;
        checks++;
        if (c !== e.cyc || sine_ch !== e.ch || sine !== e.val || sine_all !== seen_all()) begin
          errors++;
          $display("FAIL rr sample: cyc=%0d ch=%0d sine=%h all=%h want cyc=%0d ch=%0d sine=%h all=%h",
                   c, sine_ch, sine, sine_all, e.cyc, e.ch, e.val, seen_all());
        end
      end
    end
    en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rr timeout: %0d samples missing, want 0", exp_q.size()); end
  endtask

  task automatic test_collision();
    int          c;
    exp_t        e;
    logic [15:0] prev2;
    do_reset();
    load_tones();
    for (int s = 0; s < 6; s++) begin
      if (s == 2) prev2 = plan_slot(s, 4 * s + 4);
      else void'(plan_slot(s, 4 * s + 4));
    end
    // Slot 6 (ch2) is lost to the load; model takes the new state instead.
    m_load(2, 16'h5A82, 16'h5A82, 16'h1000);
    for (int s = 7; s < 12; s++) void'(plan_slot(s, 4 * s + 4));
    en = 1'b1; c = 0;
    while (exp_q.size() > 0 && c < 200) begin
      @(negedge clk); c++;
      if (c == 28) begin
        checks++;
        if (sine_valid !== 1'b0 || sine_all[47:32] !== prev2) begin
          errors++;
          $display("FAIL collide slot: valid=%b all[2]=%h want valid=0 all[2]=%h", sine_valid, sine_all[47:32], prev2);
        end
      end
      if (sine_valid) begin
        e = exp_q.pop_front();
        m_seen[e.ch] = e.val;
        checks++;
        if (c !== e.cyc || sine_ch !== e.ch || sine !== e.val || sine_all !== seen_all()) begin
          errors++;
          $display("FAIL collide sample: cyc=%0d ch=%0d sine=%h all=%h want cyc=%0d ch=%0d sine=%h all=%h",
                   c, sine_ch, sine, sine_all, e.cyc, e.ch, e.val, seen_all());
        end
      end
      // Cycle 26 is P2 of ch2 in its second round.
      if (c == 26) begin
        load = 1'b1; load_ch = 2'd2; load_cos = 16'h5A82; load_sin = 16'h5A82; load_amp = 16'h1000;
      end else begin
        load = 1'b0;
      end
    end
    en = 1'b0; load = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL collide timeout: %0d samples missing, want 0", exp_q.size()); end
  endtask

  task automatic test_enable_gating();
    int   c;
    exp_t e;
    do_reset();
    load_tones();
    void'(plan_slot(0, 4));
    for (int s = 1; s < 8; s++) void'(plan_slot(s, 4 * s + 4 + 7));
    en = 1'b1; c = 0;
    while (exp_q.size() > 0 && c < 200) begin
      @(negedge clk); c++;
      if (c >= 6 && c <= 12) begin
        checks++;
        if (sine_valid !== 1'b0 || sine !== m_seen[0] || sine_all !== seen_all()) begin
          errors++;
          $display("FAIL gate hold: cyc=%0d valid=%b sine=%h all=%h want valid=0 sine=%h all=%h",
                   c, sine_valid, sine, sine_all, m_seen[0], seen_all());
        end
      end
      if (sine_valid) begin
        e = exp_q.pop_front();
        m_seen[e.ch] = e.val;
        checks++;
        if (c !== e.cyc || sine_ch !== e.ch || sine !== e.val || sine_all !== seen_all()) begin
          errors++;
          $display("FAIL gate sample: cyc=%0d ch=%0d sine=%h all=%h want cyc=%0d ch=%0d sine=%h all=%h",
                   c, sine_ch, sine, sine_all, e.cyc, e.ch, e.val, seen_all());
        end
      end
      // Cycle 5 is P1 of slot 1: stall for 7 edges.
      if (c == 5) en = 1'b0;
      if (c == 12) en = 1'b1;
    end
    en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL gate timeout: %0d samples missing, want 0", exp_q.size()); end
  endtask

  initial begin
    reset_b = 1'b0;
    en = 1'b0; load = 1'b0; load_ch = '0;
    load_cos = '0; load_sin = '0; load_amp = '0;
    test_reset();
    test_quarter();
    test_reset_mid();
    test_saturation();
    test_round_robin();
    test_collision();
    test_enable_gating();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
